// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package rr_arb_pkg;

  localparam int N_REQ     = 4;
  localparam int SEL_W     = 2;
  localparam int Q_DEFAULT = 10;

  typedef logic [0:0] arb_state_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority search: first set req bit at start, start+1, ... mod 4.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [SEL_W-1:0] pos;
      assign pos     = start + SEL_W'(gi);
      assign rot[gi] = req[pos];
    end
  endgenerate

  // Scan from the far end so the lowest rotated offset wins.
  always_comb begin
    found = |rot;
    idx   = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = start + SEL_W'(i);
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a registered 4:1 data mux with a bounded grant quantum.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int QUANTUM = Q_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [7:0] CNT_LOAD = 8'(QUANTUM - 1);

  arb_state_t       state_reg;
  logic [7:0]       cnt_reg;
  logic             release_now;
  logic [SEL_W-1:0] pick_start;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [WIDTH-1:0] mux_data;

  assign release_now = (state_reg == ST_GRANT) && (!req[sel] || (cnt_reg == 8'd0));
  assign busy        = |gnt;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_start = '0;
`else
  logic [SEL_W-1:0] last_reg;

  // At release the search continues past the holder; from IDLE it continues past the last winner.
  assign pick_start = (state_reg == ST_GRANT) ? sel + 2'd1 : last_reg + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 2'd3;
    end else if (pick_found && ((state_reg == ST_IDLE) || release_now)) begin
      last_reg <= pick_idx;
    end
  end
`endif

  rr_pick u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    mux_data = in1;
    case (sel)
      2'd0:    mux_data = in1;
      2'd1:    mux_data = in2;
      2'd2:    mux_data = in3;
      default: mux_data = in4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      gnt       <= '0;
      sel       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          out_valid <= 1'b0;
          if (pick_found) begin
            gnt       <= idx2onehot(pick_idx);
            sel       <= pick_idx;
            cnt_reg   <= CNT_LOAD;
            state_reg <= ST_GRANT;
          end
        end
        default: begin
          // The holder's sample is captured even on the releasing edge.
          out       <= mux_data;
          out_valid <= 1'b1;
          if (release_now) begin
            if (pick_found) begin
              gnt     <= idx2onehot(pick_idx);
              sel     <= pick_idx;
              cnt_reg <= CNT_LOAD;
            end else begin
              gnt       <= '0;
              state_reg <= ST_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
      endcase
    end
  end

endmodule
